// File: rtl/alu9900_pkg.sv
// Shared ALU opcodes and multiply/divide sequencer state encodings.
package alu9900_pkg;

    localparam logic [3:0] ALU_LOAD1 = 4'h0;
    localparam logic [3:0] ALU_ADD   = 4'h2;
    localparam logic [3:0] ALU_SUB   = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ITER  = 2'd2,
        ST_DONE  = 2'd3
    } mdState_t;

endpackage

// File: rtl/alu9900.sv
// Combinational 16-bit ALU used beside muldiv9900; carry on SUB means "no borrow".
module alu9900
    import alu9900_pkg::*;
(
    input  logic [16:0] alu_arg1,
    input  logic [15:0] alu_arg2,
    input  logic [3:0]  alu_ope,
    output logic [15:0] alu_result,
    output logic        alu_carry
);

    logic [16:0] w_sum;
    logic [16:0] w_diff;

    assign w_sum  = alu_arg1 + {1'b0, alu_arg2};
    assign w_diff = alu_arg1 - {1'b0, alu_arg2};

    always_comb begin
        alu_result = alu_arg1[15:0];
        alu_carry  = 1'b0;
        case (alu_ope)
            ALU_ADD: begin
                alu_result = w_sum[15:0];
                alu_carry  = w_sum[16];
            end
            ALU_SUB: begin
                alu_result = w_diff[15:0];
                alu_carry  = (alu_arg1 >= {1'b0, alu_arg2});
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv9900.sv
// Iterative 16x16 multiply / 32/16 restoring divide sequencer driving an external ALU.
// Optional macro MULDIV_ZERO_SKIP_EN shortcuts zero-operand cases.
module muldiv9900
    import alu9900_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op_div,
    input  logic [15:0] da_hi,
    input  logic [15:0] da_lo,
    input  logic [15:0] sa,
    output logic        busy,
    output logic        done,
    output logic [15:0] res_hi,
    output logic [15:0] res_lo,
    output logic        overflow,
    output logic [16:0] alu_arg1,
    output logic [15:0] alu_arg2,
    output logic [3:0]  alu_ope,
    output logic        alu_compare,
    input  logic [15:0] alu_result,
    input  logic        alu_carry
);

    mdState_t    r_state;
    mdState_t    w_nextState;
    logic [3:0]  r_cnt;
    logic        r_opDiv;
    logic [15:0] r_sa;
    logic [15:0] r_wHi;
    logic [15:0] r_wLo;
    logic        r_done;
    logic [15:0] r_resHi;
    logic [15:0] r_resLo;
    logic        r_ovf;
    logic [15:0] w_divShift;

`ifdef MULDIV_ZERO_SKIP_EN
    logic w_mpyZero;
    assign w_mpyZero = (da_hi == 16'h0000) || (sa == 16'h0000);
`endif

    // During DIV, r_wHi is the partial remainder and r_wLo shifts dividend bits out / quotient bits in.
    assign w_divShift  = {r_wHi[14:0], r_wLo[15]};
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign res_hi      = r_resHi;
    assign res_lo      = r_resLo;
    assign overflow    = r_ovf;
    assign alu_compare = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        alu_ope     = ALU_LOAD1;
        alu_arg1    = 17'h0;
        alu_arg2    = 16'h0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = op_div ? ST_CHECK : ST_ITER;
`ifdef MULDIV_ZERO_SKIP_EN
                    if (!op_div && w_mpyZero) w_nextState = ST_DONE;
`endif
                end
            end
            ST_CHECK: begin
                alu_ope  = ALU_SUB;
                alu_arg1 = {1'b0, r_wHi};
                alu_arg2 = r_sa;
                if (alu_carry) w_nextState = ST_DONE;
`ifdef MULDIV_ZERO_SKIP_EN
                else if ((r_wHi == 16'h0000) && (r_wLo == 16'h0000)) w_nextState = ST_DONE;
`endif
                else w_nextState = ST_ITER;
            end
            ST_ITER: begin
                if (r_opDiv) begin
                    alu_ope  = ALU_SUB;
                    alu_arg1 = {r_wHi, r_wLo[15]};
                    alu_arg2 = r_sa;
                end else begin
                    alu_arg1 = {1'b0, r_wHi};
                    if (r_wLo[0]) begin
                        alu_ope  = ALU_ADD;
                        alu_arg2 = r_sa;
                    end
                end
                if (r_cnt == 4'd15) w_nextState = ST_DONE;
            end
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= 4'd0;
            r_opDiv <= 1'b0;
            r_sa    <= 16'h0;
            r_wHi   <= 16'h0;
            r_wLo   <= 16'h0;
            r_done  <= 1'b0;
            r_resHi <= 16'h0;
            r_resLo <= 16'h0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opDiv <= op_div;
                        r_sa    <= sa;
                        r_ovf   <= 1'b0;
                        r_cnt   <= 4'd0;
                        if (op_div) begin
                            r_wHi <= da_hi;
                            r_wLo <= da_lo;
                        end else begin
                            r_wHi <= 16'h0;
`ifdef MULDIV_ZERO_SKIP_EN
                            r_wLo <= w_mpyZero ? 16'h0 : da_hi;
`else
                            r_wLo <= da_hi;
`endif
                        end
                    end
                end
                ST_CHECK: begin
                    if (alu_carry) r_ovf <= 1'b1;
                end
                ST_ITER: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_opDiv) begin
                        r_wHi <= alu_carry ? alu_result : w_divShift;
                        r_wLo <= {r_wLo[14:0], alu_carry};
                    end else begin
                        {r_wHi, r_wLo} <= {alu_carry, alu_result, r_wLo[15:1]};
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                    // A completed divide holds quotient in r_wLo and remainder in r_wHi.
                    if (r_opDiv && !r_ovf) begin
                        r_resHi <= r_wLo;
                        r_resLo <= r_wHi;
                    end else begin
                        r_resHi <= r_wHi;
                        r_resLo <= r_wLo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv9900.sv
// Scoreboard bench for muldiv9900 with its ALU; reference results come from plain arithmetic.
module tb_muldiv9900;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        op_div;
    logic [15:0] da_hi;
    logic [15:0] da_lo;
    logic [15:0] sa;
    logic        busy;
    logic        done;
    logic [15:0] res_hi;
    logic [15:0] res_lo;
    logic        overflow;
    logic [16:0] alu_arg1;
    logic [15:0] alu_arg2;
    logic [3:0]  alu_ope;
    logic        alu_compare;
    logic [15:0] alu_result;
    logic        alu_carry;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        ovf;
        int          lat;
        int          acceptCyc;
    } exp_t;

    exp_t sbQ[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    muldiv9900 dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_div(op_div),
        .da_hi(da_hi), .da_lo(da_lo), .sa(sa),
        .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .overflow(overflow),
        .alu_arg1(alu_arg1), .alu_arg2(alu_arg2), .alu_ope(alu_ope), .alu_compare(alu_compare),
        .alu_result(alu_result), .alu_carry(alu_carry)
    );

    alu9900 alu (
        .alu_arg1(alu_arg1), .alu_arg2(alu_arg2), .alu_ope(alu_ope),
        .alu_result(alu_result), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic exp_t model(input logic opd, input logic [15:0] hi, input logic [15:0] lo,
                                   input logic [15:0] s);
        exp_t e;
        longint unsigned dvd;
        longint unsigned prod;
        e.acceptCyc = 0;
        if (!opd) begin
            prod  = longint'(hi) * longint'(s);
            e.hi  = prod[31:16];
            e.lo  = prod[15:0];
            e.ovf = 1'b0;
            e.lat = 17;
`ifdef MULDIV_ZERO_SKIP_EN
            if (hi == 16'h0 || s == 16'h0) e.lat = 1;
`endif
        end else if (hi >= s) begin
            e.hi  = hi;
            e.lo  = lo;
            e.ovf = 1'b1;
            e.lat = 2;
        end else begin
            dvd   = {32'h0, hi, lo};
            e.hi  = 16'(dvd / longint'(s));
            e.lo  = 16'(dvd % longint'(s));
            e.ovf = 1'b0;
            e.lat = 18;
`ifdef MULDIV_ZERO_SKIP_EN
            if (hi == 16'h0 && lo == 16'h0) e.lat = 2;
`endif
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("res_hi", 64'(res_hi), 64'(e.hi));
                checkOutput("res_lo", 64'(res_lo), 64'(e.lo));
                checkOutput("overflow", 64'(overflow), 64'(e.ovf));
                checkOutput("latency", 64'(cyc - e.acceptCyc), 64'(e.lat));
            end
        end
    end

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout_%s actual=pending required=done", name);
            sbQ.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic opd, input logic [15:0] hi, input logic [15:0] lo,
                         input logic [15:0] s);
        exp_t e;
        op_div = opd;
        da_hi  = hi;
        da_lo  = lo;
        sa     = s;
        start  = 1'b1;
        e = model(opd, hi, lo, s);
        e.acceptCyc = cyc + 1;
        sbQ.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic applyStimulus(input logic opd, input logic [15:0] hi, input logic [15:0] lo,
                                 input logic [15:0] s, input string name);
        issue(opd, hi, lo, s);
        waitDrain(name);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_res_hi"}, 64'(res_hi), 64'd0);
        checkOutput({tag, "_res_lo"}, 64'(res_lo), 64'd0);
        checkOutput({tag, "_overflow"}, 64'(overflow), 64'd0);
        checkOutput({tag, "_alu_ope"}, 64'(alu_ope), 64'd0);
        checkOutput({tag, "_alu_arg1"}, 64'(alu_arg1), 64'd0);
        checkOutput({tag, "_alu_arg2"}, 64'(alu_arg2), 64'd0);
        checkOutput({tag, "_alu_compare"}, 64'(alu_compare), 64'd0);
    endtask

    initial begin
        logic        opd;
        logic [15:0] h;
        logic [15:0] l;
        logic [15:0] s;
        reset_n = 1'b0;
        start   = 1'b0;
        op_div  = 1'b0;
        da_hi   = 16'h0;
        da_lo   = 16'h0;
        sa      = 16'h0;
        #12;
        checkAllZero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 16'h1234, 16'h0000, 16'h5678, "mpy_1234x5678");
        applyStimulus(1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, "mpy_ffffxffff");
        applyStimulus(1'b1, 16'h0001, 16'h0000, 16'h0003, "div_10000by3");
        applyStimulus(1'b1, 16'h0005, 16'h1234, 16'h0005, "div_ovf_eq");
        applyStimulus(1'b1, 16'h0005, 16'h1234, 16'h0000, "div_ovf_zero");
        applyStimulus(1'b0, 16'h1234, 16'h0000, 16'h0000, "mpy_sa_zero");
        applyStimulus(1'b1, 16'h0000, 16'h0000, 16'h0007, "div_zero_dvd");
        applyStimulus(1'b1, 16'hFFFE, 16'hFFFF, 16'hFFFF, "div_max");

        for (int i = 0; i < 40; i++) begin
            opd = 1'($urandom_range(0, 1));
            l   = 16'($urandom);
            if (!opd) begin
                h = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                s = 16'($urandom);
            end else begin
                s = 16'($urandom_range(1, 65535));
                if ($urandom_range(0, 3) == 0) h = 16'($urandom_range(int'(s), 65535));
                else                           h = 16'($urandom % s);
            end
            applyStimulus(opd, h, l, s, "random");
            checkOutput("res_hold_hi", 64'(res_hi), 64'(res_hi === 16'hx ? 16'h0 : res_hi));
        end

        // A second start while busy must not disturb the running multiply.
        issue(1'b0, 16'h1234, 16'h0000, 16'h5678);
        repeat (4) @(negedge clk);
        op_div = 1'b1;
        da_hi  = 16'h0001;
        da_lo  = 16'h0000;
        sa     = 16'h0003;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waitDrain("start_while_busy");

        // Reset mid-divide discards everything and must not produce done.
        op_div = 1'b1;
        da_hi  = 16'h0001;
        da_lo  = 16'h2345;
        sa     = 16'h0009;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        checkAllZero("after_reset");

        applyStimulus(1'b1, 16'h0001, 16'h0000, 16'h0003, "post_reset_div");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
